// File: rtl/mailbox_pkg.sv
// Shared mailbox types, opcodes, CSR offsets and IRQ bit positions.
// Consumed by mailbox_endpoint and its core-side CSR bridge.
package mailbox_pkg;

    typedef logic [7:0] mailbox_tag_t;

    localparam logic [3:0] OPC_DATA = 4'h1;

    localparam logic [31:0] MBX_CSR_TX_DEST  = 32'h00;
    localparam logic [31:0] MBX_CSR_TX_CTRL  = 32'h04;
    localparam logic [31:0] MBX_CSR_TX_DATA  = 32'h08;
    localparam logic [31:0] MBX_CSR_STATUS   = 32'h0C;
    localparam logic [31:0] MBX_CSR_RX_DATA  = 32'h10;
    localparam logic [31:0] MBX_CSR_RX_TAG   = 32'h14;
    localparam logic [31:0] MBX_CSR_IRQ_EN   = 32'h18;
    localparam logic [31:0] MBX_CSR_IRQ_STAT = 32'h1C;

    localparam int MBX_IRQ_RX_AVAIL     = 0;
    localparam int MBX_IRQ_TX_DONE      = 1;
    localparam int MBX_IRQ_RX_UNDERFLOW = 2;

    typedef struct packed {
        logic [3:0] opcode;
        logic       eop;
        logic       prio;
    } mbx_tx_ctrl_t;

    function automatic logic [31:0] mbx_lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/mailbox_csr_bridge.sv
// Wishbone CSR front end for one mailbox endpoint: TX beat launcher, one-entry RX hold, maskable irq.
// Ack one cycle after request; a TX_DATA write while a beat is pending stalls until the handshake.
module mailbox_csr_bridge
    import mailbox_pkg::*;
#(
    parameter int         ADDR_W     = 5,
    parameter logic [3:0] RST_OPCODE = OPC_DATA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_wb_cyc,
    input  logic              s_wb_stb,
    input  logic              s_wb_we,
    input  logic [ADDR_W-1:0] s_wb_adr,
    input  logic [31:0]       s_wb_dat_w,
    input  logic [3:0]        s_wb_sel,
    output logic [31:0]       s_wb_dat_r,
    output logic              s_wb_ack,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [15:0]       tx_dest,
    output logic [31:0]       tx_data,
    output logic              tx_prio,
    output logic              tx_eop,
    output logic [3:0]        tx_opcode,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [31:0]       rx_data,
    input  mailbox_tag_t      rx_tag,
    output logic              irq
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]   state_q, state_d;
    logic         ack_q, ack_d;
    logic [31:0]  dat_r_q, dat_r_d;
    logic [15:0]  dest_q, dest_d;
    mbx_tx_ctrl_t ctrl_q, ctrl_d;
    logic [2:0]   irq_en_q, irq_en_d;
    logic         done_q, done_d;
    logic         unf_q, unf_d;
    logic         irq_q, irq_d;
    logic         hold_vld_q, hold_vld_d;
    logic [31:0]  hold_dat_q, hold_dat_d;
    mailbox_tag_t hold_tag_q, hold_tag_d;
    logic         pop_q, pop_d;
    logic [15:0]  txo_dest_q, txo_dest_d;
    logic [31:0]  txo_dat_q, txo_dat_d;
    mbx_tx_ctrl_t txo_ctrl_q, txo_ctrl_d;

    logic [31:0] csr_adr;
    logic [31:0] lane;
    logic [31:0] rdata;
    logic [2:0]  irq_stat;
    logic        access, tx_busy, stall, wr, rd, rx_fire, unf_evt;

    assign csr_adr  = 32'(s_wb_adr) & ~32'h3;
    assign lane     = mbx_lane_mask(s_wb_sel);
    assign tx_busy  = (state_q == ST_PEND);
    assign access   = s_wb_cyc & s_wb_stb & ~ack_q;
    assign stall    = access & s_wb_we & (csr_adr == MBX_CSR_TX_DATA) & tx_busy;
    assign wr       = access & ~stall & s_wb_we;
    assign rd       = access & ~s_wb_we;
    assign rx_fire  = rx_valid & ~hold_vld_q;
    assign unf_evt  = rd & (csr_adr == MBX_CSR_RX_DATA) & ~hold_vld_q;
    assign irq_stat = {unf_q, done_q, hold_vld_q};

    always_comb begin
        rdata = 32'h0;
        case (csr_adr)
            MBX_CSR_TX_DEST:  rdata = {16'h0, dest_q};
            MBX_CSR_TX_CTRL:  rdata = {24'h0, ctrl_q.opcode, 2'b00, ctrl_q.eop, ctrl_q.prio};
            MBX_CSR_STATUS:   rdata = {28'h0, irq_q, unf_q, hold_vld_q, tx_busy};
            MBX_CSR_RX_DATA:  rdata = hold_vld_q ? hold_dat_q : 32'h0;
            MBX_CSR_RX_TAG:   rdata = 32'(hold_tag_q);
            MBX_CSR_IRQ_EN:   rdata = {29'h0, irq_en_q};
            MBX_CSR_IRQ_STAT: rdata = {29'h0, irq_stat};
            default:          rdata = 32'h0;
        endcase
    end

    always_comb begin
        ack_d      = wr | rd;
        dat_r_d    = rd ? rdata : 32'h0;
        dest_d     = dest_q;
        ctrl_d     = ctrl_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        unf_d      = unf_q;
        state_d    = state_q;
        txo_dest_d = txo_dest_q;
        txo_dat_d  = txo_dat_q;
        txo_ctrl_d = txo_ctrl_q;
        hold_vld_d = hold_vld_q;
        hold_dat_d = hold_dat_q;
        hold_tag_d = hold_tag_q;
        pop_d      = rd & (csr_adr == MBX_CSR_RX_DATA) & hold_vld_q;

        if (wr) begin
            case (csr_adr)
                MBX_CSR_TX_DEST: begin
                    if (s_wb_sel[0]) dest_d[7:0]  = s_wb_dat_w[7:0];
                    if (s_wb_sel[1]) dest_d[15:8] = s_wb_dat_w[15:8];
                end
                MBX_CSR_TX_CTRL: begin
                    if (s_wb_sel[0]) ctrl_d = '{opcode: s_wb_dat_w[7:4], eop: s_wb_dat_w[1],
                                                prio: s_wb_dat_w[0]};
                end
                MBX_CSR_IRQ_EN: begin
                    if (s_wb_sel[0]) irq_en_d = s_wb_dat_w[2:0];
                end
                MBX_CSR_IRQ_STAT: begin
                    if (s_wb_sel[0] && s_wb_dat_w[MBX_IRQ_TX_DONE])      done_d = 1'b0;
                    if (s_wb_sel[0] && s_wb_dat_w[MBX_IRQ_RX_UNDERFLOW]) unf_d  = 1'b0;
                end
                default: ;
            endcase
        end

        // Stall guarantees a TX_DATA write only lands while IDLE.
        if (wr && csr_adr == MBX_CSR_TX_DATA) begin
            state_d    = ST_PEND;
            txo_dat_d  = s_wb_dat_w & lane;
            txo_dest_d = dest_q;
            txo_ctrl_d = ctrl_q;
        end else if (tx_busy && tx_ready) begin
            state_d = ST_IDLE;
        end

        // Event sets are applied after W1C so a coincident set wins.
        if (tx_busy && tx_ready) done_d = 1'b1;
        if (unf_evt)             unf_d  = 1'b1;

        // Pop lands at the end of the ack cycle, giving one bubble before the next capture.
        if (pop_q) begin
            hold_vld_d = 1'b0;
        end else if (rx_fire) begin
            hold_vld_d = 1'b1;
            hold_dat_d = rx_data;
            hold_tag_d = rx_tag;
        end

        irq_d = |(irq_stat & irq_en_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            dat_r_q    <= 32'h0;
            dest_q     <= 16'h0;
            ctrl_q     <= '{opcode: RST_OPCODE, eop: 1'b1, prio: 1'b0};
            irq_en_q   <= 3'h0;
            done_q     <= 1'b0;
            unf_q      <= 1'b0;
            irq_q      <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_dat_q <= 32'h0;
            hold_tag_q <= '0;
            pop_q      <= 1'b0;
            txo_dest_q <= 16'h0;
            txo_dat_q  <= 32'h0;
            txo_ctrl_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_r_q    <= dat_r_d;
            dest_q     <= dest_d;
            ctrl_q     <= ctrl_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            unf_q      <= unf_d;
            irq_q      <= irq_d;
            hold_vld_q <= hold_vld_d;
            hold_dat_q <= hold_dat_d;
            hold_tag_q <= hold_tag_d;
            pop_q      <= pop_d;
            txo_dest_q <= txo_dest_d;
            txo_dat_q  <= txo_dat_d;
            txo_ctrl_q <= txo_ctrl_d;
        end
    end

    assign s_wb_ack   = ack_q;
    assign s_wb_dat_r = dat_r_q;
    assign tx_valid   = tx_busy;
    assign tx_dest    = txo_dest_q;
    assign tx_data    = txo_dat_q;
    assign tx_prio    = txo_ctrl_q.prio;
    assign tx_eop     = txo_ctrl_q.eop;
    assign tx_opcode  = txo_ctrl_q.opcode;
    assign rx_ready   = ~hold_vld_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_mailbox_csr_bridge.sv
// Directed plus randomized bench for mailbox_csr_bridge against a register-level reference model.
module tb_mailbox_csr_bridge;
    import mailbox_pkg::*;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_wb_cyc = 1'b0, s_wb_stb = 1'b0, s_wb_we = 1'b0;
    logic [AW-1:0] s_wb_adr = '0;
    logic [31:0]   s_wb_dat_w = 32'h0;
    logic [3:0]    s_wb_sel = 4'h0;
    logic [31:0]   s_wb_dat_r;
    logic          s_wb_ack;
    logic          tx_valid, tx_prio, tx_eop, rx_ready, irq;
    logic          tx_ready = 1'b0;
    logic [15:0]   tx_dest;
    logic [31:0]   tx_data;
    logic [3:0]    tx_opcode;
    logic          rx_valid = 1'b0;
    logic [31:0]   rx_data = 32'h0;
    mailbox_tag_t  rx_tag = '0;

    mailbox_csr_bridge #(.ADDR_W(AW), .RST_OPCODE(OPC_DATA)) dut (
        .clk(clk), .rst(rst),
        .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we), .s_wb_adr(s_wb_adr),
        .s_wb_dat_w(s_wb_dat_w), .s_wb_sel(s_wb_sel), .s_wb_dat_r(s_wb_dat_r), .s_wb_ack(s_wb_ack),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_data(tx_data),
        .tx_prio(tx_prio), .tx_eop(tx_eop), .tx_opcode(tx_opcode),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_tag(rx_tag), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dest;
        logic [31:0] data;
        logic        prio;
        logic        eop;
        logic [3:0]  opc;
    } beat_t;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int vcnt = 0;
    int last_ack_cyc = 0;
    beat_t obs_q[$];
    beat_t exp_q[$];
    int    obs_vcnt[$];
    int    obs_cyc[$];

    // reference model state
    logic [15:0] m_dest;
    logic        m_prio, m_eop, m_done, m_unf, m_avail;
    logic [3:0]  m_opc;
    logic [2:0]  m_en;
    logic [31:0] m_hdata;
    logic [7:0]  m_htag;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (rst) begin
            vcnt = 0;
        end else if (tx_valid) begin
            vcnt = vcnt + 1;
            if (tx_ready) begin
                obs_q.push_back('{dest: tx_dest, data: tx_data, prio: tx_prio, eop: tx_eop, opc: tx_opcode});
                obs_vcnt.push_back(vcnt);
                obs_cyc.push_back(cyc_cnt);
                vcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dest = 16'h0; m_prio = 1'b0; m_eop = 1'b1; m_opc = OPC_DATA; m_en = 3'h0;
        m_done = 1'b0; m_unf = 1'b0; m_avail = 1'b0; m_hdata = 32'h0; m_htag = 8'h0;
    endtask

    function automatic logic m_irq();
        return |({m_unf, m_done, m_avail} & m_en);
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] adr);
        case (int'(adr) / 4)
            0: return {16'h0, m_dest};
            1: return {24'h0, m_opc, 2'b00, m_eop, m_prio};
            3: return {28'h0, m_irq(), m_unf, m_avail, 1'b0};
            4: return m_avail ? m_hdata : 32'h0;
            5: return {24'h0, m_htag};
            6: return {29'h0, m_en};
            7: return {29'h0, m_unf, m_done, m_avail};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [AW-1:0] adr, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] masked;
        masked = d & {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        case (int'(adr) / 4)
            0: begin
                if (sel[0]) m_dest[7:0] = d[7:0];
                if (sel[1]) m_dest[15:8] = d[15:8];
            end
            1: if (sel[0]) begin m_prio = d[0]; m_eop = d[1]; m_opc = d[7:4]; end
            2: begin
                exp_q.push_back('{dest: m_dest, data: masked, prio: m_prio, eop: m_eop, opc: m_opc});
                m_done = 1'b1;
            end
            6: if (sel[0]) m_en = d[2:0];
            7: if (sel[0]) begin
                if (d[1]) m_done = 1'b0;
                if (d[2]) m_unf = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic wb_raw(input logic we, input logic [AW-1:0] adr, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rd, output int lat);
        @(negedge clk);
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = we; s_wb_adr = adr; s_wb_dat_w = d; s_wb_sel = sel;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (s_wb_ack !== 1'b1 && lat < 200);
        check("ack_seen", 64'(s_wb_ack), 64'd1);
        rd = s_wb_dat_r;
        last_ack_cyc = cyc_cnt;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
    endtask

    task automatic idle2();
        @(posedge clk); #1;
        check("ack_single", 64'(s_wb_ack), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [AW-1:0] adr, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] rd;
        int lat;
        wb_raw(1'b1, adr, d, sel, rd, lat);
        model_write(adr, d, sel);
        idle2();
    endtask

    task automatic do_read(input logic [AW-1:0] adr, output logic [31:0] rd);
        logic [31:0] exp;
        logic is_rx, had;
        int lat;
        exp = model_read(adr);
        is_rx = (int'(adr) / 4 == 4);
        had = m_avail;
        wb_raw(1'b0, adr, 32'h0, 4'h0, rd, lat);
        check($sformatf("read@%02h", adr), 64'(rd), 64'(exp));
        if (is_rx && had) begin
            check("rx_ready_in_pop_ack", 64'(rx_ready), 64'd0);
            @(posedge clk); #1;
            check("rx_ready_after_pop", 64'(rx_ready), 64'd1);
            @(posedge clk); #1;
            m_avail = 1'b0;
        end else begin
            idle2();
            if (is_rx) m_unf = 1'b1;
        end
    endtask

    task automatic rx_push(input logic [31:0] d, input logic [7:0] t);
        int n;
        n = 0;
        @(negedge clk);
        while (rx_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("rx_ready_wait", 64'(rx_ready), 64'd1);
        rx_valid = 1'b1; rx_data = d; rx_tag = t;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        m_avail = 1'b1; m_hdata = d; m_htag = t;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic check_beats();
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check("beat", 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
            void'(obs_vcnt.pop_front());
            void'(obs_cyc.pop_front());
        end
        check("beat_backlog", 64'(obs_q.size()), 64'(exp_q.size()));
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        int hs_cyc;
        logic [AW-1:0] wr_list[5];
        logic [AW-1:0] adr;
        wr_list = '{6'h00, 6'h04, 6'h08, 6'h18, 6'h1C};
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        #1;
        check("rst_rx_ready", 64'(rx_ready), 64'd1);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        wb_raw(1'b0, 6'h04, 32'h0, 4'h0, rd, lat);
        check("rst_tx_ctrl", 64'(rd), 64'h12);
        check("ack_latency", 64'(lat), 64'd1);
        idle2();
        do_read(6'h0C, rd);
        check("rst_status", 64'(rd), 64'h0);

        // 2: single beat with ready endpoint
        tx_ready = 1'b1;
        do_write(6'h00, 32'h0000_1101, 4'hF);
        do_write(6'h08, 32'hDEAD_BEEF, 4'hF);
        check("beat1_seen", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0) begin
            check("beat1_vcycles", 64'(obs_vcnt[0]), 64'd1);
            check("beat1_dest", 64'(obs_q[0].dest), 64'h1101);
            check("beat1_data", 64'(obs_q[0].data), 64'hDEADBEEF);
        end
        check_beats();
        do_read(6'h1C, rd);
        check("tx_done_set", 64'(rd[1]), 64'd1);

        // 3: stalled second write
        tx_ready = 1'b0;
        do_write(6'h08, 32'h1111_1111, 4'hF);
        fork
            do_write(6'h08, 32'h2222_2222, 4'hF);
            begin repeat (10) @(negedge clk); tx_ready = 1'b1; end
        join
        check("stall_beats", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() > 0) begin
            hs_cyc = obs_cyc[0];
            check("stall_first_data", 64'(obs_q[0].data), 64'h11111111);
            check("stall_ack_after_hs", 64'(last_ack_cyc), 64'(hs_cyc + 2));
        end
        check_beats();

        // 4: RX capture and pop
        rx_push(32'hCAFE_BABE, 8'h5A);
        check("rx_ready_full", 64'(rx_ready), 64'd0);
        do_read(6'h0C, rd);
        check("status_avail", 64'(rd[1]), 64'd1);
        do_read(6'h14, rd);
        check("rx_tag", 64'(rd), 64'h5A);
        do_read(6'h10, rd);
        check("rx_data", 64'(rd), 64'hCAFEBABE);

        // 5: underflow and irq
        do_read(6'h10, rd);
        check("underflow_data", 64'(rd), 64'h0);
        do_read(6'h0C, rd);
        check("status_unf", 64'(rd[2]), 64'd1);
        do_write(6'h18, 32'h4, 4'h1);
        check("irq_unf", 64'(irq), 64'd1);
        do_write(6'h1C, 32'h4, 4'h1);
        check("irq_cleared", 64'(irq), 64'd0);

        // 6: reset while pending and holding
        tx_ready = 1'b0;
        wb_raw(1'b1, 6'h08, 32'h3333_3333, 4'hF, rd, lat);
        idle2();
        rx_push(32'h1234_5678, 8'h77);
        check("pend_tx_valid", 64'(tx_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_tx_drop", 64'(tx_valid), 64'd0);
        check("async_rx_ready", 64'(rx_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        obs_q.delete(); exp_q.delete(); obs_vcnt.delete(); obs_cyc.delete();
        do_read(6'h0C, rd);
        check("status_after_rst", 64'(rd), 64'h0);
        do_read(6'h04, rd);

        // randomized traffic against the model
        tx_ready = 1'b1;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    adr = wr_list[$urandom_range(0, 4)] | AW'($urandom_range(0, 3));
                    do_write(adr, $urandom, 4'($urandom_range(0, 15)));
                end
                2: do_write(AW'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
                3: do_read(AW'($urandom_range(0, 63)), rd);
                4: do_read(($urandom_range(0, 1) == 0) ? 6'h10 : 6'h0C, rd);
                default: if (!m_avail) rx_push($urandom, 8'($urandom));
            endcase
            check("rand_irq", 64'(irq), 64'(m_irq()));
            check("rand_rx_ready", 64'(rx_ready), 64'(!m_avail));
        end
        check_beats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mailbox_csr_bridge.md
Name: mailbox_csr_bridge

Overview:
Core-side register front end for one mailbox_endpoint. It turns Wishbone-style CSR loads and stores from a core into beats on the endpoint's tx_valid/tx_ready interface. It drains the endpoint's rx_valid/rx_ready stream into a software-readable holding register. It raises a maskable interrupt line. It sits between the core's MMIO decoder, which handles base-address decode, and mailbox_endpoint.

Parameters:
ADDR_W, 5, CSR byte-address width; registers are word-aligned and adr[1:0] is ignored.
RST_OPCODE, OPC_DATA, reset value of TX_CTRL.opcode.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
s_wb_cyc  in  1  CSR bus cycle
s_wb_stb  in  1  CSR strobe
s_wb_we  in  1  write enable
s_wb_adr  in  ADDR_W  byte address
s_wb_dat_w  in  32  write data
s_wb_sel  in  4  byte lanes; a write updates only the lanes where sel is set
s_wb_dat_r  out  32  read data, valid with ack
s_wb_ack  out  1  single-cycle acknowledge
tx_valid  out  1  to endpoint tx_valid
tx_ready  in  1  from endpoint
tx_dest  out  16  {cluster, local id}
tx_data  out  32  beat payload
tx_prio  out  1  priority
tx_eop  out  1  end of packet
tx_opcode  out  4  opcode
rx_valid  in  1  from endpoint
rx_ready  out  1  to endpoint
rx_data  in  32  beat payload
rx_tag  in  mailbox_tag_t  beat tag
irq  out  1  level interrupt to the core

Behaviour:
- Reset values: all outputs are 0 except rx_ready=1. Reset clears TX_DEST, IRQ_EN, sticky bits and the RX hold, and sets TX_CTRL to {opcode=RST_OPCODE, eop=1, prio=0}.
- Register map:
  - 0x00 TX_DEST, R/W, bits [15:0].
  - 0x04 TX_CTRL, R/W: [0] prio, [1] eop, [7:4] opcode.
  - 0x08 TX_DATA, write-only: pushes a beat; reads return 0.
  - 0x0C STATUS, RO: [0] tx_busy, [1] rx_avail, [2] rx_underflow, [3] irq.
  - 0x10 RX_DATA, RO: reading it pops the hold.
  - 0x14 RX_TAG, RO: tag of the held beat, zero-extended to 32 bits; reading it does not pop.
  - 0x18 IRQ_EN, R/W, bits [2:0].
  - 0x1C IRQ_STAT, write-1-to-clear on bits [2:1]: [0] rx_avail (level), [1] tx_done (sticky), [2] rx_underflow (sticky).
  - Any other address reads 0, writes are ignored, and the access is still acked.
- Ack: registered. s_wb_ack asserts for exactly one cycle, one cycle after a cycle in which cyc&stb&!ack is true. The bridge never acks two back-to-back cycles.
  - Exception: a write to TX_DATA while tx_busy=1 stalls. Ack is withheld until tx_busy clears; the write is then accepted and acked on the following cycle.
- TX FSM states are IDLE and PEND.
  - IDLE→PEND on an accepted TX_DATA write. In that transition tx_data is latched from dat_w (sel-masked, unwritten lanes 0), tx_dest/prio/eop/opcode are snapshotted from the shadow registers, and tx_valid=1.
  - PEND→IDLE on the cycle where tx_valid&tx_ready; tx_done sets on that same cycle.
  - Outputs stay stable throughout PEND. Shadow-register writes during PEND change only the next beat.
  - tx_busy = (state==PEND).
- RX hold is a one-entry buffer.
  - rx_ready = !hold_valid.
  - On rx_valid&rx_ready, data and tag are captured and hold_valid=1.
  - An RX_DATA read returns the held data and clears hold_valid in its ack cycle. rx_ready therefore reasserts the next cycle, leaving a one-cycle bubble between pop and the next capture.
  - An RX_DATA read while the hold is empty returns 0 and sets rx_underflow.
- Interrupt: irq = |(IRQ_STAT[2:0] & IRQ_EN[2:0]), registered, so it asserts one cycle after the cause.
  - If a W1C write and a set event hit the same bit in the same cycle, set wins.
- Reset mid-operation: a pending beat is dropped (tx_valid→0 asynchronously), the held RX beat is discarded, and an in-flight CSR access gets no ack.

Decomposition:
- mailbox_pkg gains:
  - CSR offset localparams: MBX_CSR_TX_DEST, MBX_CSR_TX_CTRL, MBX_CSR_TX_DATA, MBX_CSR_STATUS, MBX_CSR_RX_DATA, MBX_CSR_RX_TAG, MBX_CSR_IRQ_EN, MBX_CSR_IRQ_STAT.
  - IRQ bit-index constants.
  - A packed mbx_tx_ctrl_t struct.
- mailbox_tag_t and the OPC_* opcode constants are used as already defined in mailbox_pkg.
- The block is a single module with no sub-module; the one-entry RX hold is inline.

Test Plan:
1. After reset: read TX_CTRL → 0x00000012, STATUS → 0, irq=0, rx_ready=1.
2. Write TX_DEST=0x1101, TX_DATA=0xDEADBEEF with tx_ready=1 → tx_valid high for 1 cycle carrying dest 0x1101 and data 0xDEADBEEF; IRQ_STAT[1]=1.
3. Hold tx_ready=0 for 10 cycles, write TX_DATA=0x11111111, then TX_DATA=0x22222222 → the second write's ack is stalled until the first beat's handshake; beats go out in order.
4. Endpoint presents 0xCAFEBABE → rx_ready drops; STATUS[1]=1; RX_TAG returns the tag; RX_DATA returns 0xCAFEBABE; rx_ready reasserts the next cycle.
5. Read RX_DATA while empty → returns 0 and STATUS[2]=1; with IRQ_EN=0x4, irq=1; write IRQ_STAT=0x4 → irq=0.
6. Assert rst while in PEND with the hold full → tx_valid=0 immediately; STATUS reads 0 after reset.
